// File: rtl/instr_reg.sv
// instr_reg: assembles one 2*DW-bit instruction from two byte fetches (high byte first)
// and presents its opcode and operand address once the instruction is complete.
module instr_reg #(
  parameter int DW  = 8,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic           clr,
  input  logic [DW-1:0]  data,
  output logic [OPW-1:0] opcode,
  output logic [DW-1:0]  ir_ad,
  output logic           ir_valid,
  output logic           fetch_lo
);
  localparam logic [0:0] S_HI = 1'b0;
  localparam logic [0:0] S_LO = 1'b1;
  logic [0:0]     state;
  // Only the opcode bits of the staged high byte matter; the reserved bits are dropped.
  logic [OPW-1:0] hi_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= S_HI;
      hi_q     <= '0;
      opcode   <= '0;
      ir_ad    <= '0;
      ir_valid <= 1'b0;
    end else if (clr) begin
      state    <= S_HI;
      ir_valid <= 1'b0;
    end else if (ena) begin
      if (state == S_HI) begin
        hi_q     <= data[DW-1 -: OPW];
        state    <= S_LO;
        ir_valid <= 1'b0;
      end else begin
        opcode   <= hi_q;
        ir_ad    <= data;
        ir_valid <= 1'b1;
        state    <= S_HI;
      end
    end
  assign fetch_lo = (state == S_LO);
endmodule

// File: tb/tb_instr_reg.sv
// tb_instr_reg: directed and randomized checks of instr_reg against a byte-queue model.
module tb_instr_reg;
  localparam int DW = 8;
  localparam int OPW = 3;
  logic clk = 1'b0, rst = 1'b1, ena = 1'b0, clr = 1'b0;
  logic [DW-1:0] data = '0;
  logic [OPW-1:0] opcode;
  logic [DW-1:0] ir_ad;
  logic ir_valid, fetch_lo;
  int tests = 0, fails = 0;
  bit started = 1'b0;
  int q[$];
  int m_op = 0, m_ad = 0;
  bit m_valid = 1'b0;

  instr_reg #(.DW(DW), .OPW(OPW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .clr(clr), .data(data),
    .opcode(opcode), .ir_ad(ir_ad), .ir_valid(ir_valid), .fetch_lo(fetch_lo)
  );

  always #5 clk = ~clk;

  // Model: bytes captured since the last complete instruction or flush form a queue.
  always @(posedge rst) begin
    q.delete(); m_op = 0; m_ad = 0; m_valid = 1'b0;
  end
  always @(posedge clk) begin
    if (rst) begin
      q.delete(); m_op = 0; m_ad = 0; m_valid = 1'b0;
    end else if (clr) begin
      q.delete(); m_valid = 1'b0;
    end else if (ena) begin
      q.push_back(int'(data));
      if (q.size() == 1) m_valid = 1'b0;
      if (q.size() == 2) begin
        m_op = q[0] >> (DW - OPW);
        m_ad = q[1];
        m_valid = 1'b1;
        q.delete();
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (started) begin
    chk("cmp_opcode", int'(opcode), m_op);
    chk("cmp_ir_ad", int'(ir_ad), m_ad);
    chk("cmp_ir_valid", int'(ir_valid), int'(m_valid));
    chk("cmp_fetch_lo", int'(fetch_lo), int'(q.size() == 1));
  end

  task automatic step(input logic e, input logic c, input logic [DW-1:0] d);
    ena = e; clr = c; data = d;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    chk("reset_opcode", int'(opcode), 0);
    chk("reset_valid", int'(ir_valid), 0);
    chk("reset_fetch_lo", int'(fetch_lo), 0);
    @(negedge clk);
    rst = 1'b0;
    started = 1'b1;
    // 1: single instruction
    step(1, 0, 8'hA5);
    chk("t1_fetch_lo_mid", int'(fetch_lo), 1);
    chk("t1_valid_mid", int'(ir_valid), 0);
    chk("t1_opcode_mid", int'(opcode), 0);
    step(1, 0, 8'h3C);
    chk("t1_opcode", int'(opcode), 5);
    chk("t1_ir_ad", int'(ir_ad), 'h3C);
    chk("t1_valid", int'(ir_valid), 1);
    chk("t1_fetch_lo", int'(fetch_lo), 0);
    // 2: back-to-back
    step(1, 0, 8'hA5);
    step(1, 0, 8'h3C);
    chk("t2_e2_opcode", int'(opcode), 5);
    step(1, 0, 8'hE0);
    chk("t2_e3_valid", int'(ir_valid), 0);
    chk("t2_e3_opcode", int'(opcode), 5);
    chk("t2_e3_ir_ad", int'(ir_ad), 'h3C);
    step(1, 0, 8'hFF);
    chk("t2_e4_opcode", int'(opcode), 7);
    chk("t2_e4_ir_ad", int'(ir_ad), 'hFF);
    chk("t2_e4_valid", int'(ir_valid), 1);
    // 3: long wait in the low-byte phase
    step(1, 0, 8'h40);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 8'($urandom));
      chk("t3_gap_fetch_lo", int'(fetch_lo), 1);
    end
    step(1, 0, 8'h12);
    chk("t3_opcode", int'(opcode), 2);
    chk("t3_ir_ad", int'(ir_ad), 'h12);
    // 4: clr beats ena
    step(1, 0, 8'hA5);
    step(1, 1, 8'h77);
    chk("t4_fetch_lo", int'(fetch_lo), 0);
    chk("t4_valid", int'(ir_valid), 0);
    step(1, 0, 8'h20);
    step(1, 0, 8'h01);
    chk("t4_opcode", int'(opcode), 1);
    chk("t4_ir_ad", int'(ir_ad), 'h01);
    // 5: asynchronous reset mid-fetch
    step(1, 0, 8'hC0);
    ena = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t5_async_opcode", int'(opcode), 0);
    chk("t5_async_ir_ad", int'(ir_ad), 0);
    chk("t5_async_fetch_lo", int'(fetch_lo), 0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 8'h60);
    step(1, 0, 8'h08);
    chk("t5_opcode", int'(opcode), 3);
    chk("t5_ir_ad", int'(ir_ad), 'h08);
    // 6: flush keeps the fields
    step(1, 0, 8'hC0);
    step(1, 0, 8'h55);
    step(0, 1, 8'h00);
    chk("t6_valid", int'(ir_valid), 0);
    chk("t6_opcode", int'(opcode), 6);
    chk("t6_ir_ad", int'(ir_ad), 'h55);
    chk("t6_fetch_lo", int'(fetch_lo), 0);
    // randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      ena = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 19) == 0);
      data = 8'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
      @(negedge clk);
    end
    started = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
